// File: rtl/d_mem_responder.sv
// Multi-cycle data-memory responder: one outstanding load/store, LATENCY wait states,
// byte-enable stores, and misaligned/out-of-range error reporting.
//   state | meaning
//   IDLE  | ready to accept a request
//   WAIT  | counting down wait states; access happens when the counter reaches 0
//   RESP  | response held on resp_* until resp_ready
module d_mem_responder #(
    parameter int ADDR_WIDTH = 8,
    parameter int LATENCY    = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t          state;
    state_t          state_next;
    logic [3:0]      count;
    logic            lat_write;
    logic [31:0]     lat_addr;
    logic [31:0]     lat_wdata;
    logic [3:0]      lat_be;
    logic [31:0]     mem [2**ADDR_WIDTH];
    logic [ADDR_WIDTH-1:0] word_index;
    logic            access_error;
    logic            access_now;

    assign word_index   = lat_addr[ADDR_WIDTH+1:2];
    assign access_error = (lat_addr[1:0] != 2'b00) || ((lat_addr[31:2] >> ADDR_WIDTH) != 30'd0);
    assign access_now   = (state == WAIT) && (count == 4'd0);

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid) state_next = WAIT;
            end
            WAIT: begin
                if (count == 4'd0) state_next = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count      <= 4'd0;
            resp_rdata <= 32'd0;
            resp_error <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        lat_write <= req_write;
                        lat_addr  <= req_addr;
                        lat_wdata <= req_wdata;
                        lat_be    <= req_be;
                        count     <= 4'(LATENCY);
                    end
                end
                WAIT: begin
                    if (count != 4'd0) begin
                        count <= count - 4'd1;
                    end else begin
                        resp_rdata <= (lat_write || access_error) ? 32'd0 : mem[word_index];
                        resp_error <= access_error;
                    end
                end
                default: ;
            endcase
        end
    end

    // Memory is deliberately not reset; reset on the commit edge must still block the write.
    always_ff @(posedge clock) begin
        if (access_now && lat_write && !access_error && !reset) begin
            for (int b = 0; b < 4; b++) begin
                if (lat_be[b]) mem[word_index][8*b +: 8] <= lat_wdata[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_d_mem_responder.sv
// Directed self-checking bench for d_mem_responder (LATENCY=2 main instance,
// LATENCY=0 second instance for the zero-wait-state case).
module tb_d_mem_responder;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_be;
    logic        resp_valid, resp_ready, resp_error, busy;
    logic [31:0] resp_rdata;

    logic        z_req_valid, z_req_ready, z_req_write;
    logic [31:0] z_req_addr, z_req_wdata;
    logic [3:0]  z_req_be;
    logic        z_resp_valid, z_resp_ready, z_resp_error, z_busy;
    logic [31:0] z_resp_rdata;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    d_mem_responder #(.ADDR_WIDTH(8), .LATENCY(2)) u_dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_error(resp_error), .busy(busy)
    );

    d_mem_responder #(.ADDR_WIDTH(8), .LATENCY(0)) u_dut_lat0 (
        .clock(clock), .reset(reset),
        .req_valid(z_req_valid), .req_ready(z_req_ready), .req_write(z_req_write),
        .req_addr(z_req_addr), .req_wdata(z_req_wdata), .req_be(z_req_be),
        .resp_valid(z_resp_valid), .resp_ready(z_resp_ready),
        .resp_rdata(z_resp_rdata), .resp_error(z_resp_error), .busy(z_busy)
    );

    // Issue one request on the LATENCY=2 instance with resp_ready high; reports the
    // number of edges from acceptance to resp_valid (capped at 40).
    task automatic do_req(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, output logic [31:0] rdata, output logic err,
                          output int lat);
        req_write = wr; req_addr = addr; req_wdata = wdata; req_be = be;
        resp_ready = 1'b1; req_valid = 1'b1;
        @(posedge clock); #1;
        req_valid = 1'b0; req_addr = 32'hFFFF_FFFF; req_wdata = 32'h0; req_be = 4'h0;
        lat = 0;
        while (!resp_valid && lat < 40) begin
            @(posedge clock); #1;
            lat++;
        end
        rdata = resp_rdata;
        err   = resp_error;
        @(posedge clock); #1;
    endtask

    task automatic z_issue(input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
        z_req_write = wr; z_req_addr = addr; z_req_wdata = wdata; z_req_be = 4'hF;
        z_resp_ready = 1'b1; z_req_valid = 1'b1;
        @(posedge clock); #1;
        z_req_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
        total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL reset_resp_valid got=%b exp=0", resp_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (resp_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", resp_rdata); end
        total++; if (resp_error !== 1'b0) begin bad++; $display("FAIL reset_error got=%b exp=0", resp_error); end
        reset = 1'b0;
    endtask

    task automatic test_store_load();
        logic [31:0] rd; logic er; int lat;
        do_req(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, rd, er, lat);
        total++; if (lat != 3) begin bad++; $display("FAIL store_latency got=%0d exp=3", lat); end
        total++; if (er !== 1'b0 || rd !== 32'h0) begin bad++; $display("FAIL store_resp got=%b/%h exp=0/0", er, rd); end
        total++; if (busy !== 1'b0 || req_ready !== 1'b1) begin bad++; $display("FAIL store_idle got busy=%b ready=%b exp=0/1", busy, req_ready); end
        do_req(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
        total++; if (rd !== 32'hDEAD_BEEF || er !== 1'b0) begin bad++; $display("FAIL load_0x10 got=%h/%b exp=deadbeef/0", rd, er); end
        total++; if (lat != 3) begin bad++; $display("FAIL load_latency got=%0d exp=3", lat); end
    endtask

    task automatic test_byte_enable();
        logic [31:0] rd; logic er; int lat;
        do_req(1'b1, 32'h10, 32'h0000_AA00, 4'b0010, rd, er, lat);
        do_req(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
        total++; if (rd !== 32'hDEAD_AAEF) begin bad++; $display("FAIL be_lane1 got=%h exp=deadaaef", rd); end
        do_req(1'b1, 32'h10, 32'hFFFF_FFFF, 4'b0000, rd, er, lat);
        total++; if (er !== 1'b0 || rd !== 32'h0 || lat != 3) begin bad++; $display("FAIL be_zero_resp got=%b/%h/%0d exp=0/0/3", er, rd, lat); end
        do_req(1'b0, 32'h10, 32'h0, 4'hF, rd, er, lat);
        total++; if (rd !== 32'hDEAD_AAEF) begin bad++; $display("FAIL be_zero_noop got=%h exp=deadaaef", rd); end
    endtask

    task automatic test_backpressure();
        logic [31:0] rd; logic er; int lat; int n;
        resp_ready = 1'b0;
        req_write = 1'b0; req_addr = 32'h10; req_be = 4'hF; req_valid = 1'b1;
        @(posedge clock); #1;
        req_valid = 1'b0;
        n = 0;
        while (!resp_valid && n < 40) begin @(posedge clock); #1; n++; end
        total++; if (n != 3) begin bad++; $display("FAIL bp_latency got=%0d exp=3", n); end
        for (int i = 0; i < 5; i++) begin
            req_valid = (i % 2 == 0); req_write = 1'b1; req_addr = 32'h10;
            req_wdata = 32'h0; req_be = 4'hF;
            @(posedge clock); #1;
            total++;
            if (resp_valid !== 1'b1 || resp_rdata !== 32'hDEAD_AAEF || req_ready !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold[%0d] got valid=%b rdata=%h ready=%b exp=1/deadaaef/0", i, resp_valid, resp_rdata, req_ready);
            end
        end
        req_valid = 1'b0; resp_ready = 1'b1;
        @(posedge clock); #1;
        total++; if (busy !== 1'b0 || resp_valid !== 1'b0) begin bad++; $display("FAIL bp_release got busy=%b valid=%b exp=0/0", busy, resp_valid); end
        do_req(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
        total++; if (rd !== 32'hDEAD_AAEF) begin bad++; $display("FAIL bp_no_accept got=%h exp=deadaaef", rd); end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic er; int lat;
        do_req(1'b1, 32'h12, 32'h5555_5555, 4'hF, rd, er, lat);
        total++; if (er !== 1'b1 || rd !== 32'h0 || lat != 3) begin bad++; $display("FAIL err_misaligned got=%b/%h/%0d exp=1/0/3", er, rd, lat); end
        do_req(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
        total++; if (rd !== 32'hDEAD_AAEF || er !== 1'b0) begin bad++; $display("FAIL err_no_write got=%h/%b exp=deadaaef/0", rd, er); end
        do_req(1'b0, 32'h400, 32'h0, 4'h0, rd, er, lat);
        total++; if (er !== 1'b1 || rd !== 32'h0 || lat != 3) begin bad++; $display("FAIL err_range got=%b/%h/%0d exp=1/0/3", er, rd, lat); end
        do_req(1'b0, 32'h3FC, 32'h0, 4'h0, rd, er, lat);
        total++; if (er !== 1'b0) begin bad++; $display("FAIL err_top_word got=%b exp=0", er); end
    endtask

    task automatic test_reset_mid_wait();
        logic [31:0] rd; logic er; int lat;
        do_req(1'b1, 32'h20, 32'h1111_1111, 4'hF, rd, er, lat);
        req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'h2222_2222; req_be = 4'hF; req_valid = 1'b1;
        @(posedge clock); #1;
        req_valid = 1'b0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        total++; if (busy !== 1'b1 || resp_valid !== 1'b0) begin bad++; $display("FAIL mid_wait_state got busy=%b valid=%b exp=1/0", busy, resp_valid); end
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        total++; if (req_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL mid_wait_abort got ready=%b busy=%b exp=1/0", req_ready, busy); end
        for (int i = 0; i < 4; i++) begin
            total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL mid_wait_no_resp[%0d] got=%b exp=0", i, resp_valid); end
            @(posedge clock); #1;
        end
        do_req(1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat);
        total++; if (rd !== 32'h1111_1111) begin bad++; $display("FAIL mid_wait_mem got=%h exp=11111111", rd); end
    endtask

    task automatic test_latency0();
        z_issue(1'b1, 32'h20, 32'h1111_1111);
        total++; if (z_resp_valid !== 1'b0 || z_busy !== 1'b1) begin bad++; $display("FAIL lat0_wait got valid=%b busy=%b exp=0/1", z_resp_valid, z_busy); end
        @(posedge clock); #1;
        total++; if (z_resp_valid !== 1'b1 || z_resp_error !== 1'b0) begin bad++; $display("FAIL lat0_resp got valid=%b err=%b exp=1/0", z_resp_valid, z_resp_error); end
        @(posedge clock); #1;
        total++; if (z_busy !== 1'b0) begin bad++; $display("FAIL lat0_idle got=%b exp=0", z_busy); end
        z_issue(1'b1, 32'h20, 32'h2222_2222);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        total++; if (z_resp_valid !== 1'b0 || z_busy !== 1'b0) begin bad++; $display("FAIL lat0_abort got valid=%b busy=%b exp=0/0", z_resp_valid, z_busy); end
        z_issue(1'b0, 32'h20, 32'h0);
        @(posedge clock); #1;
        total++; if (z_resp_valid !== 1'b1 || z_resp_rdata !== 32'h1111_1111) begin bad++; $display("FAIL lat0_mem got valid=%b rdata=%h exp=1/11111111", z_resp_valid, z_resp_rdata); end
        @(posedge clock); #1;
    endtask

    initial begin
        reset = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; req_be = 4'h0;
        resp_ready = 1'b1;
        z_req_valid = 1'b0; z_req_write = 1'b0; z_req_addr = 32'h0; z_req_wdata = 32'h0; z_req_be = 4'h0;
        z_resp_ready = 1'b1;
        test_reset();
        test_store_load();
        test_byte_enable();
        test_backpressure();
        test_errors();
        test_reset_mid_wait();
        test_latency0();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/d_mem_responder.md
Name: d_mem_responder

Overview:
- Multi-cycle data-memory responder. It serves load/store requests from the datapath over a valid/ready request channel and a valid/ready response channel.
- It takes the memory end of the datapath's data-memory interface and replaces the zero-latency combinational memory with one that has configurable wait states.
- It allows one outstanding request at a time, handles byte-enable writes and flags misaligned or out-of-range accesses.

Parameters:
- ADDR_WIDTH, 8, word-index width; memory depth is 2**ADDR_WIDTH 32-bit words.
- LATENCY, 2, wait cycles inserted before the access; legal range 0..15.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_write  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data.
- req_be  input  4  store byte enables; be[0] selects bits 7:0 (little-endian lanes).
- resp_valid  output  1  response present.
- resp_ready  input  1  requester accepts the response.
- resp_rdata  output  32  load data; 0 for stores and for errors.
- resp_error  output  1  access was misaligned or out of range.
- busy  output  1  a request is in flight (state is not IDLE).

Behaviour:
- Reset values: req_ready=1, resp_valid=0, resp_rdata=0, resp_error=0, busy=0, state=IDLE, wait counter=0.
- Reset does not clear memory. Contents are undefined until written.
- FSM states:
  - IDLE: req_ready=1. On an edge with req_valid&&req_ready, latch write, addr, wdata and be, load counter=LATENCY, go to WAIT.
  - WAIT: req_ready=0. If counter!=0, decrement it. If counter==0, perform the access at this edge, register the result, go to RESP.
  - RESP: resp_valid=1. resp_rdata and resp_error stay stable until an edge with resp_ready=1, which moves to IDLE. resp_valid=0 from the next cycle.
- Timing:
  - resp_valid rises LATENCY+1 edges after the accepting edge.
  - Minimum round trip with resp_ready held high is LATENCY+3 cycles from acceptance to the next accept.
- Error check: a request is an error if req_addr[1:0]!=0 or req_addr[31:2] >= 2**ADDR_WIDTH.
  - On error: no memory write, resp_rdata=0, resp_error=1.
  - An error response still goes through WAIT and RESP with the same latency.
- Store access:
  - Each byte lane with be=1 is updated from wdata; lanes with be=0 are unchanged.
  - be=4'b0000 is a legal no-op store with a normal response.
  - A store response has resp_rdata=0 and resp_error=0.
- Load access: returns the full word regardless of be.
- Ordering: only one request is outstanding, so a load issued after a store's response sees the stored data.
- Request inputs are ignored outside IDLE. They need not be held stable after acceptance.
- Reset mid-operation: reset in WAIT aborts the request. An uncommitted store is never written, and no response is produced. Reset in RESP drops the pending response.
- A combinational path from req_valid to req_ready or resp_valid is not permitted; both are registered state decodes.

Test Plan:
- Reset: assert reset 2 cycles -> req_ready=1, resp_valid=0, busy=0, resp_rdata=0, resp_error=0.
- LATENCY=2 store then load:
  - Store 0xDEADBEEF to 0x10 with be=4'hF, accepted at edge t -> resp_valid=1 after edge t+3, resp_error=0.
  - With resp_ready=1, IDLE after edge t+4.
  - Then load 0x10 -> resp_rdata=0xDEADBEEF.
- Byte enable: after the previous step, store 0x0000AA00 to 0x10 with be=4'b0010 -> a load of 0x10 returns 0xDEADAAEF.
- Backpressure: load response with resp_ready=0 for 5 cycles while req_valid=1 toggles -> resp_valid and resp_rdata stay stable, req_ready=0, no new request is accepted; release resp_ready -> IDLE on the next cycle.
- Errors with ADDR_WIDTH=8:
  - Store to 0x12 -> resp_error=1, resp_rdata=0; a load of 0x10 is unchanged.
  - Load 0x400 -> resp_error=1, resp_rdata=0.
- Reset mid-WAIT:
  - Store 0x11111111 to 0x20; then start a store of 0x22222222 to 0x20 and assert reset in WAIT -> no resp_valid.
  - A load of 0x20 afterwards returns 0x11111111.
  - Repeat with LATENCY=0 -> resp_valid after edge t+1.
